// File: rtl/ipml_reg_fifo_v2_fft_stream_fifo_pkg.sv
// Shared helpers for FFT stream blocks: width derivation, parameter legality
// checks and the handshake-op encoding used by occupancy counters.

`ifndef FFT_STREAM_PARAM_CHECK
`define FFT_STREAM_PARAM_CHECK(ok, msg) \
  if (!(ok)) begin : g_param_check \
    $error(msg); \
  end
`endif

package ipml_reg_fifo_v2_fft_stream_fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Level must represent 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int af_level,
                                        input int ae_level);
    return (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level < depth);
  endfunction

  // {write, read} handshake pair as seen by an occupancy counter.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

endpackage

// File: rtl/ipml_reg_fifo_v2_fft_stream_fifo_if.sv
// Valid/ready stream bundle for the FFT stream FIFO, plus flush and status.
// master = upstream producer / downstream consumer side, slave = the FIFO.

interface ipml_reg_fifo_v2_fft_stream_fifo_if
  import ipml_reg_fifo_v2_fft_stream_fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) ();
  localparam int LW = lvl_width(DEPTH);

  logic          flush;
  logic          data_in_valid;
  logic [W-1:0]  data_in;
  logic          data_in_ready;
  logic          data_out_ready;
  logic [W-1:0]  data_out;
  logic          data_out_valid;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  modport master (
    output flush, data_in_valid, data_in, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, level, almost_full, almost_empty
  );

  modport slave (
    input  flush, data_in_valid, data_in, data_out_ready,
    output data_in_ready, data_out, data_out_valid, level, almost_full, almost_empty
  );

endinterface

// File: rtl/ipml_reg_fifo_v2_fft_stream_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer counter with increment and synchronous clear; wraps
// explicitly from DEPTH-1 to 0 so non-power-of-two depths are legal.

module ipml_wrap_ptr
  import ipml_reg_fifo_v2_fft_stream_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      if (r_ptr == PW'(DEPTH - 1)) r_ptr <= '0;
      else                         r_ptr <= r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ipml_reg_fifo_v2_fft_stream_fifo.sv
// Register-based first-word-fall-through valid/ready FIFO for FFT streams,
// any DEPTH >= 2, with occupancy level, almost flags and synchronous flush.

module ipml_reg_fifo_v2_fft_stream_fifo
  import ipml_reg_fifo_v2_fft_stream_fifo_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic                                clk,
  input logic                                rst_n,
  ipml_reg_fifo_v2_fft_stream_fifo_if.slave  bus
);

  localparam int LW = lvl_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  `FFT_STREAM_PARAM_CHECK(fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL),
                          "ipml_reg_fifo_v2_fft_stream_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL")

  logic [W-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_level;
  logic [PW-1:0] w_wptr;
  logic [PW-1:0] w_rptr;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_write;
  logic          w_read;
  logic          w_wr_en;
  logic          w_rd_en;
  fifo_op_t      w_op;

  // Ready depends only on registered level: no path from data_out_ready.
  assign w_in_ready  = (r_level != LW'(DEPTH));
  assign w_out_valid = (r_level != '0);
  assign w_write     = bus.data_in_valid & w_in_ready;
  assign w_read      = w_out_valid & bus.data_out_ready;
  assign w_wr_en     = w_write & ~bus.flush;
  assign w_rd_en     = w_read & ~bus.flush;
  assign w_op        = fifo_op_t'({w_wr_en, w_rd_en});

  ipml_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr_en),
    .i_clr (bus.flush),
    .o_ptr (w_wptr)
  );

  ipml_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_en),
    .i_clr (bus.flush),
    .o_ptr (w_rptr)
  );

  // NOTE: storage is flat flops cleared by reset so data_out reads 0 afterwards; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en && (w_wptr == PW'(i))) r_mem[i] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (bus.flush) begin
      r_level <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_level <= r_level + LW'(1);
        OP_POP:  r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.data_in_ready  = w_in_ready;
  assign bus.data_out_valid = w_out_valid;
  assign bus.data_out       = r_mem[w_rptr];
  assign bus.level          = r_level;
  assign bus.almost_full    = (r_level >= LW'(AF_LEVEL));
  assign bus.almost_empty   = (r_level <= LW'(AE_LEVEL));

endmodule

// File: tb/tb_ipml_reg_fifo_v2_fft_stream_fifo.sv
// Directed bench for the FFT stream FIFO: a DEPTH=4 instance for the main
// scenarios and a DEPTH=3 instance for the non-power-of-two stream.

module tb_ipml_reg_fifo_v2_fft_stream_fifo;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ipml_reg_fifo_v2_fft_stream_fifo_if #(.W(8), .DEPTH(4)) bus4 ();
  ipml_reg_fifo_v2_fft_stream_fifo_if #(.W(8), .DEPTH(3)) bus3 ();

  ipml_reg_fifo_v2_fft_stream_fifo #(.W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  ipml_reg_fifo_v2_fft_stream_fifo #(.W(8), .DEPTH(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the edge to sample/drive.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.flush = 1'b0; bus4.data_in_valid = 1'b0; bus4.data_in = '0; bus4.data_out_ready = 1'b0;
    bus3.flush = 1'b0; bus3.data_in_valid = 1'b0; bus3.data_in = '0; bus3.data_out_ready = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus4.level); end
    n_checks++; if (bus4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus4.data_in_ready); end
    n_checks++; if (bus4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus4.data_out_valid); end
    n_checks++; if (bus4.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got=%b exp=1", bus4.almost_empty); end
    n_checks++; if (bus4.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got=%b exp=0", bus4.almost_full); end
    n_checks++; if (bus4.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", bus4.data_out); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] wr_vals [4];
    logic [7:0] rd_vals [5];
    wr_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus4.data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.data_in_valid = 1'b1;
      bus4.data_in       = wr_vals[i];
      cyc();
      n_checks++; if (bus4.level !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, bus4.level, i + 1); end
      n_checks++; if (bus4.almost_full !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, bus4.almost_full, (i + 1 >= 3)); end
      n_checks++; if (bus4.almost_empty !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, bus4.almost_empty, (i + 1 <= 1)); end
      n_checks++; if (bus4.data_in_ready !== (i != 3)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, bus4.data_in_ready, (i != 3)); end
      n_checks++; if (bus4.data_out !== 8'h11) begin n_fail++; $display("FAIL fill_head[%0d] got=%h exp=11", i, bus4.data_out); end
    end
    // Fifth beat held while full must be refused.
    bus4.data_in = 8'h55;
    cyc();
    cyc();
    n_checks++; if (bus4.level !== 3'd4) begin n_fail++; $display("FAIL full_level got=%0d exp=4", bus4.level); end
    n_checks++; if (bus4.data_out !== 8'h11) begin n_fail++; $display("FAIL full_head_stable got=%h exp=11", bus4.data_out); end
    bus4.data_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== rd_vals[k]) begin
        n_fail++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", k, bus4.data_out_valid, bus4.data_out, rd_vals[k]);
      end
      if (k == 0) begin
        n_checks++; if (bus4.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_full got=%b exp=0", bus4.data_in_ready); end
      end
      if (k == 1) begin
        n_checks++; if (bus4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_after_read got=%b exp=1", bus4.data_in_ready); end
      end
      cyc();
      if (k == 1) bus4.data_in_valid = 1'b0;
    end
    bus4.data_out_ready = 1'b0;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL drain_level got=%0d exp=0", bus4.level); end
    n_checks++; if (bus4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got=%b exp=0", bus4.data_out_valid); end
    n_checks++; if (bus4.almost_empty !== 1'b1) begin n_fail++; $display("FAIL drain_almost_empty got=%b exp=1", bus4.almost_empty); end
  endtask

  task automatic test_back_to_back();
    bus4.data_out_ready = 1'b0;
    bus4.data_in_valid  = 1'b1;
    bus4.data_in        = 8'h60;
    cyc();
    bus4.data_in = 8'h61;
    cyc();
    n_checks++; if (bus4.level !== 3'd2) begin n_fail++; $display("FAIL b2b_prefill_level got=%0d exp=2", bus4.level); end
    bus4.data_out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus4.data_in = 8'(8'h62 + j);
      n_checks++; if (bus4.data_out !== 8'(8'h60 + j)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", j, bus4.data_out, 8'(8'h60 + j)); end
      n_checks++; if (bus4.level !== 3'd2) begin n_fail++; $display("FAIL b2b_level[%0d] got=%0d exp=2", j, bus4.level); end
      cyc();
    end
    bus4.data_in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      n_checks++; if (bus4.data_out !== 8'(8'h6A + j)) begin n_fail++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", j, bus4.data_out, 8'(8'h6A + j)); end
      cyc();
    end
    bus4.data_out_ready = 1'b0;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL b2b_end_level got=%0d exp=0", bus4.level); end
  endtask

  task automatic test_flush();
    bus4.data_out_ready = 1'b0;
    bus4.data_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus4.data_in = 8'(8'h71 + i);
      cyc();
    end
    n_checks++; if (bus4.level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_level got=%0d exp=3", bus4.level); end
    bus4.data_in        = 8'hAA;
    bus4.data_out_ready = 1'b1;
    bus4.flush          = 1'b1;
    cyc();
    bus4.flush          = 1'b0;
    bus4.data_in_valid  = 1'b0;
    bus4.data_out_ready = 1'b0;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", bus4.level); end
    n_checks++; if (bus4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", bus4.data_out_valid); end
    n_checks++; if (bus4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", bus4.data_in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus4.data_out === 8'hAA) begin n_fail++; $display("FAIL flush_dropped_beat[%0d] got=%h exp=not AA", i, bus4.data_out); end
      if (i < 2) cyc();
    end
    bus4.data_in_valid = 1'b1;
    bus4.data_in       = 8'h3C;
    cyc();
    bus4.data_in_valid = 1'b0;
    n_checks++; if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 8'h3C) begin
      n_fail++; $display("FAIL flush_next_head got=%b/%h exp=1/3c", bus4.data_out_valid, bus4.data_out);
    end
    n_checks++; if (bus4.level !== 3'd1) begin n_fail++; $display("FAIL flush_next_level got=%0d exp=1", bus4.level); end
    bus4.data_out_ready = 1'b1;
    cyc();
    bus4.data_out_ready = 1'b0;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL flush_end_level got=%0d exp=0", bus4.level); end
  endtask

  task automatic test_reset_mid();
    bus4.data_out_ready = 1'b0;
    bus4.data_in_valid  = 1'b1;
    bus4.data_in        = 8'h81;
    cyc();
    bus4.data_in = 8'h82;
    cyc();
    bus4.data_in = 8'h83;
    n_checks++; if (bus4.level !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_level got=%0d exp=2", bus4.level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got=%0d exp=0", bus4.level); end
    n_checks++; if (bus4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", bus4.data_out_valid); end
    n_checks++; if (bus4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", bus4.data_in_ready); end
    n_checks++; if (bus4.data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_out got=%h exp=00", bus4.data_out); end
    n_checks++; if (bus4.almost_empty !== 1'b1 || bus4.almost_full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags got=ae%b/af%b exp=ae1/af0", bus4.almost_empty, bus4.almost_full);
    end
    bus4.data_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    bus4.data_in_valid = 1'b1;
    bus4.data_in       = 8'h5A;
    n_checks++; if (bus4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_bypass got=%b exp=0", bus4.data_out_valid); end
    cyc();
    bus4.data_in_valid = 1'b0;
    n_checks++; if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 8'h5A) begin
      n_fail++; $display("FAIL rstmid_first_out got=%b/%h exp=1/5a", bus4.data_out_valid, bus4.data_out);
    end
    n_checks++; if (bus4.level !== 3'd1) begin n_fail++; $display("FAIL rstmid_level_after got=%0d exp=1", bus4.level); end
    bus4.data_out_ready = 1'b1;
    cyc();
    bus4.data_out_ready = 1'b0;
    n_checks++; if (bus4.level !== 3'd0) begin n_fail++; $display("FAIL rstmid_end_level got=%0d exp=0", bus4.level); end
  endtask

  task automatic test_depth3_stream();
    logic [31:0] pat;
    int idx;
    int nout;
    int lvl;
    bit wr;
    bit rd;
    pat  = 32'h6C91_B3A0;
    idx  = 0;
    nout = 0;
    lvl  = 0;
    for (int c = 0; c < 200 && nout < 20; c++) begin
      bus3.data_in_valid  = (idx < 20);
      bus3.data_in        = 8'(idx);
      bus3.data_out_ready = pat[c % 32];
      n_checks++; if (bus3.level !== 2'(lvl)) begin n_fail++; $display("FAIL d3_level[c%0d] got=%0d exp=%0d", c, bus3.level, lvl); end
      n_checks++; if (bus3.level > 2'd3) begin n_fail++; $display("FAIL d3_level_bound[c%0d] got=%0d exp<=3", c, bus3.level); end
      n_checks++; if (bus3.data_in_ready !== (lvl != 3)) begin n_fail++; $display("FAIL d3_in_ready[c%0d] got=%b exp=%b", c, bus3.data_in_ready, (lvl != 3)); end
      n_checks++; if (bus3.data_out_valid !== (lvl != 0)) begin n_fail++; $display("FAIL d3_out_valid[c%0d] got=%b exp=%b", c, bus3.data_out_valid, (lvl != 0)); end
      n_checks++; if (bus3.almost_full !== (lvl >= 2)) begin n_fail++; $display("FAIL d3_almost_full[c%0d] got=%b exp=%b", c, bus3.almost_full, (lvl >= 2)); end
      if (lvl != 0) begin
        n_checks++; if (bus3.data_out !== 8'(nout)) begin n_fail++; $display("FAIL d3_data[c%0d] got=%h exp=%h", c, bus3.data_out, 8'(nout)); end
      end
      wr = (idx < 20) && (lvl != 3);
      rd = (lvl != 0) && pat[c % 32];
      if (wr) idx++;
      if (rd) nout++;
      lvl = lvl + int'(wr) - int'(rd);
      cyc();
    end
    bus3.data_in_valid  = 1'b0;
    bus3.data_out_ready = 1'b0;
    n_checks++; if (nout != 20) begin n_fail++; $display("FAIL d3_timeout got=%0d beats exp=20", nout); end
    n_checks++; if (bus3.level !== 2'd0) begin n_fail++; $display("FAIL d3_end_level got=%0d exp=0", bus3.level); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_depth3_stream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
